attn_phase_scheduler: RTL and testbench

- Per-token phase sequencer for the self-attention pipeline. Replaces the ad-hoc token counter and phase FSM.
- For each token it drives the start/done handshakes in a fixed order: QKV projection, KV-cache write, QK score, softmax, attention multiply.
- Generates KV-cache addressing, a per-phase watchdog, a run-length cycle counter and debug state.
- Sits between the top-level start/done and the qkv, kv_cache, qk_mul, softmax_appr and attn_mul instances.

---
 rtl/attn_phase_scheduler.sv | 193 +++++++++++++++++++
 tb/tb_attn_phase_scheduler.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/attn_phase_scheduler.sv
// Per-token phase sequencer for the self-attention pipeline: QKV -> KV write
// -> QK score -> softmax -> attention multiply, with watchdog and run counters.
module attn_phase_scheduler #(
    parameter int SEQ_LEN        = 64,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [$clog2(SEQ_LEN):0]   seq_len_cfg,
    output logic                       qkv_start,
    input  logic                       qkv_done,
    output logic                       kv_write_en,
    output logic [$clog2(SEQ_LEN)-1:0] kv_addr,
    output logic                       qk_start,
    input  logic                       qk_done,
    output logic                       softmax_start,
    input  logic                       softmax_done,
    output logic                       attn_start,
    input  logic                       attn_done,
    output logic [$clog2(SEQ_LEN)-1:0] token_idx,
    output logic                       busy,
    output logic                       done,
    output logic                       error,
    output logic [CNT_WIDTH-1:0]       cycle_count,
    output logic [2:0]                 state_dbg
);

    localparam int IW = $clog2(SEQ_LEN);
    localparam int LW = IW + 1;
    localparam int WW = $clog2(TIMEOUT_CYCLES) + 1;

    // The watchdog reaches TIMEOUT_CYCLES-1 on the edge that leaves for ERR.
    localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT_CYCLES - 2);
    localparam logic [LW-1:0] LEN_MAX = LW'(SEQ_LEN);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_QKV  = 3'd1,
        S_KVWR = 3'd2,
        S_QK   = 3'd3,
        S_SMAX = 3'd4,
        S_ATTN = 3'd5,
        S_NEXT = 3'd6,
        S_ERR  = 3'd7
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [LW-1:0]   len_q;
    logic [IW-1:0]   tok_q;
    logic [WW-1:0]   wd_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic            err_q;
    logic            done_q;

    logic            cfg_ok;
    logic            accept;
    logic            in_phase;
    logic            in_run;
    logic            armed;
    logic            phase_done;
    logic            wd_expire;
    logic            last_tok;

    assign cfg_ok    = (seq_len_cfg != '0) && (seq_len_cfg <= LEN_MAX);
    assign accept    = start && ((state == S_IDLE) || (state == S_ERR));
    assign in_phase  = (state == S_QKV) || (state == S_QK) ||
                       (state == S_SMAX) || (state == S_ATTN);
    assign in_run    = (state != S_IDLE) && (state != S_ERR);
    assign armed     = (wd_q != '0);
    assign wd_expire = (wd_q == WD_LAST);
    assign last_tok  = ({1'b0, tok_q} == (len_q - LW'(1)));

    // Only the done of the active phase is looked at; others are ignored.
    always_comb begin
        phase_done = 1'b0;
        case (state)
            S_QKV:   phase_done = qkv_done;
            S_QK:    phase_done = qk_done;
            S_SMAX:  phase_done = softmax_done;
            S_ATTN:  phase_done = attn_done;
            default: phase_done = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_ERR: begin
                if (start) begin
                    state_nxt = cfg_ok ? S_QKV : S_ERR;
                end
            end
            S_QKV: begin
                if (armed && phase_done) begin
                    state_nxt = S_KVWR;
                end else if (wd_expire) begin
                    state_nxt = S_ERR;
                end
            end
            S_KVWR: state_nxt = S_QK;
            S_QK: begin
                if (armed && phase_done) begin
                    state_nxt = S_SMAX;
                end else if (wd_expire) begin
                    state_nxt = S_ERR;
                end
            end
            S_SMAX: begin
                if (armed && phase_done) begin
                    state_nxt = S_ATTN;
                end else if (wd_expire) begin
                    state_nxt = S_ERR;
                end
            end
            S_ATTN: begin
                if (armed && phase_done) begin
                    state_nxt = S_NEXT;
                end else if (wd_expire) begin
                    state_nxt = S_ERR;
                end
            end
            S_NEXT: state_nxt = last_tok ? S_IDLE : S_QKV;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            len_q  <= '0;
            tok_q  <= '0;
            wd_q   <= '0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= (state == S_NEXT) && last_tok;

            // Watchdog restarts on every state change, so wd_q==0 marks entry.
            if ((state_nxt != state) || !in_phase) begin
                wd_q <= '0;
            end else begin
                wd_q <= wd_q + WW'(1);
            end

            if (accept && cfg_ok) begin
                len_q <= seq_len_cfg;
                tok_q <= '0;
                cnt_q <= '0;
                err_q <= 1'b0;
            end else if (accept) begin
                err_q <= 1'b1;
            end else begin
                if (in_phase && (state_nxt == S_ERR)) begin
                    err_q <= 1'b1;
                end
                if (in_run && (cnt_q != '1)) begin
                    cnt_q <= cnt_q + CNT_WIDTH'(1);
                end
                if ((state == S_NEXT) && !last_tok) begin
                    tok_q <= tok_q + IW'(1);
                end
            end
        end
    end

    // Outputs decode registered state only, never the done inputs.
    always_comb begin
        qkv_start     = (state == S_QKV)  && (wd_q == '0);
        kv_write_en   = (state == S_KVWR);
        qk_start      = (state == S_QK)   && (wd_q == '0);
        softmax_start = (state == S_SMAX) && (wd_q == '0);
        attn_start    = (state == S_ATTN) && (wd_q == '0);
        kv_addr       = tok_q;
        token_idx     = tok_q;
        busy          = in_run;
        done          = done_q;
        error         = err_q;
        cycle_count   = cnt_q;
        state_dbg     = state;
    end

endmodule

// File: tb/tb_attn_phase_scheduler.sv
// Bench for attn_phase_scheduler: randomized responder delays checked against
// a per-token timeline model of strobes, done timing and cycle counts.
module tb_attn_phase_scheduler;

    localparam int SEQ_LEN = 8;
    localparam int TO      = 16;
    localparam int CW      = 32;
    localparam int IW      = 3;
    localparam int LW      = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [LW-1:0] seq_len_cfg;
    logic          qkv_start, qkv_done;
    logic          kv_write_en;
    logic [IW-1:0] kv_addr;
    logic          qk_start, qk_done;
    logic          softmax_start, softmax_done;
    logic          attn_start, attn_done;
    logic [IW-1:0] token_idx;
    logic          busy, done, error;
    logic [CW-1:0] cycle_count;
    logic [2:0]    state_dbg;

    attn_phase_scheduler #(
        .SEQ_LEN(SEQ_LEN), .TIMEOUT_CYCLES(TO), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .seq_len_cfg(seq_len_cfg),
        .qkv_start(qkv_start), .qkv_done(qkv_done),
        .kv_write_en(kv_write_en), .kv_addr(kv_addr),
        .qk_start(qk_start), .qk_done(qk_done),
        .softmax_start(softmax_start), .softmax_done(softmax_done),
        .attn_start(attn_start), .attn_done(attn_done),
        .token_idx(token_idx), .busy(busy), .done(done), .error(error),
        .cycle_count(cycle_count), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    int cyc = 0;
    int dly [SEQ_LEN][4];
    int rem [4];
    bit dn [4];
    int qkv_seen, tok, run_base;
    int done_cnt, done_rel, last_sm_cyc;
    bit frc_entry, frc_foreign;
    logic prev_busy, busy_at_done, busy_before_done;
    logic [CW-1:0] cnt_at_done;
    logic [31:0] obs[$];
    logic [31:0] expq[$];

    task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
        checks++;
        assert (o === e) begin
            passes++;
        end else begin
            $error("FAIL %s: got %0h expected %0h", tag, o, e);
        end
    endtask

    function automatic logic [31:0] ev(int t, logic [4:0] m, int i);
        return {19'(t), m, 4'(i), 4'(i)};
    endfunction

    // One clock: observe outputs of the new cycle, then drive responders.
    task automatic tick();
        logic [4:0] m;
        prev_busy = busy;
        @(posedge clk);
        #1;
        cyc++;
        for (int p = 0; p < 4; p++) begin
            if (rem[p] > 0) begin
                rem[p]--;
                dn[p] = (rem[p] == 0);
            end else begin
                dn[p] = 1'b0;
            end
        end
        m = {attn_start, softmax_start, qk_start, kv_write_en, qkv_start};
        if (m[0]) begin
            tok = qkv_seen;
            qkv_seen++;
            rem[0] = dly[tok][0];
        end
        if (m[2]) rem[1] = dly[tok][1];
        if (m[3]) begin
            rem[2] = dly[tok][2];
            last_sm_cyc = cyc;
        end
        if (m[4]) rem[3] = dly[tok][3];
        if (m != 5'd0)
            obs.push_back({19'(cyc - run_base), m, 4'(kv_addr), 4'(token_idx)});
        if (done === 1'b1) begin
            done_cnt++;
            done_rel = cyc - run_base;
            busy_at_done = busy;
            busy_before_done = prev_busy;
            cnt_at_done = cycle_count;
        end
        qkv_done     = dn[0] | (frc_entry && m[0]);
        qk_done      = dn[1];
        softmax_done = dn[2] | (frc_foreign && state_dbg == 3'd3);
        attn_done    = dn[3] | (frc_foreign && state_dbg == 3'd3);
    endtask

    task automatic fill(input int lo, input int hi);
        for (int i = 0; i < SEQ_LEN; i++)
            for (int p = 0; p < 4; p++)
                dly[i][p] = $urandom_range(hi, lo);
    endtask

    // Timeline model: a phase with done delay d lasts d+1 cycles,
    // KV write and the token step last one cycle each.
    task automatic build(input int len, output int total);
        int t = 1;
        for (int i = 0; i < len; i++) begin
            expq.push_back(ev(t, 5'd1, i));
            t += dly[i][0] + 1;
            expq.push_back(ev(t, 5'd2, i));
            t += 1;
            expq.push_back(ev(t, 5'd4, i));
            t += dly[i][1] + 1;
            expq.push_back(ev(t, 5'd8, i));
            t += dly[i][2] + 1;
            expq.push_back(ev(t, 5'd16, i));
            t += dly[i][3] + 1;
            t += 1;
        end
        total = t - 1;
    endtask

    task automatic begin_run(input int len);
        obs.delete();
        expq.delete();
        qkv_seen = 0;
        done_cnt = 0;
        for (int p = 0; p < 4; p++) rem[p] = 0;
        seq_len_cfg = LW'(len);
        start = 1'b1;
        run_base = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic do_run(input int len, input bit poke);
        int total;
        int guard = 0;
        bit poked = 0;
        logic [IW-1:0] t0;
        begin_run(len);
        build(len, total);
        chk("run_busy", busy, 1);
        chk("run_state_qkv", state_dbg, 1);
        chk("run_err_clr", error, 0);
        chk("run_cnt_clr", cycle_count, 0);
        while (done_cnt == 0 && guard < 4000) begin
            if (poke && !poked && state_dbg == 3'd3) begin
                t0 = token_idx;
                start = 1'b1;
                seq_len_cfg = 4'd1;
                tick();
                start = 1'b0;
                poked = 1;
                chk("busy_start_tok", token_idx, t0);
                chk("busy_start_state", state_dbg, 3);
            end else begin
                tick();
            end
            guard++;
        end
        chk("run_done_seen", done_cnt, 1);
        repeat (4) tick();
        chk("run_done_once", done_cnt, 1);
        chk("run_done_time", done_rel, total + 1);
        chk("run_busy_fall", busy_at_done, 0);
        chk("run_busy_before", busy_before_done, 1);
        chk("run_cnt_at_done", cnt_at_done, total);
        chk("run_cnt_hold", cycle_count, total);
        chk("run_tok_final", token_idx, len - 1);
        chk("run_no_err", error, 0);
        chk("run_ev_count", obs.size(), expq.size());
        for (int i = 0; i < obs.size() && i < expq.size(); i++)
            chk("run_event", obs[i], expq[i]);
    endtask

    task automatic bad_cfg(input int cfg);
        begin_run(cfg);
        chk("bad_state", state_dbg, 7);
        chk("bad_err", error, 1);
        chk("bad_busy", busy, 0);
        repeat (3) tick();
        chk("bad_no_strobe", obs.size(), 0);
        chk("bad_err_hold", error, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        int guard;
        int n;
        rst = 1'b1;
        start = 1'b0;
        seq_len_cfg = '0;
        qkv_done = 0;
        qk_done = 0;
        softmax_done = 0;
        attn_done = 0;
        frc_entry = 0;
        frc_foreign = 0;
        for (int p = 0; p < 4; p++) rem[p] = 0;
        repeat (2) tick();
        chk("rst_state", state_dbg, 0);
        chk("rst_outs", {qkv_start, kv_write_en, qk_start, softmax_start,
                         attn_start, busy, done, error}, 0);
        chk("rst_cnt", cycle_count, 0);
        chk("rst_tok", token_idx, 0);
        rst = 1'b0;
        tick();

        // nominal: two tokens, every responder answers after 3 cycles
        fill(3, 3);
        do_run(2, 0);
        chk("nominal_cnt36", cycle_count, 36);

        // early done on QKV entry and foreign dones while in QK
        frc_entry = 1;
        frc_foreign = 1;
        do_run(1, 0);
        frc_entry = 0;
        frc_foreign = 0;

        // longest legal done delay
        fill(TO - 2, TO - 2);
        do_run(1, 0);

        // softmax never answers
        fill(2, 2);
        dly[0][2] = 0;
        begin_run(2);
        guard = 0;
        while (state_dbg != 3'd7 && guard < 200) begin
            tick();
            guard++;
        end
        chk("to_reached", state_dbg, 7);
        chk("to_sm_rel", last_sm_cyc - run_base, 8);
        chk("to_delay", cyc - last_sm_cyc, TO - 1);
        chk("to_err", error, 1);
        chk("to_busy", busy, 0);
        chk("to_cnt", cycle_count, 8 + TO - 2);
        chk("to_ev_count", obs.size(), 4);
        n = obs.size();
        repeat (10) tick();
        chk("to_no_strobe", obs.size(), n);
        chk("to_err_hold", error, 1);
        chk("to_cnt_hold", cycle_count, 8 + TO - 2);
        fill(1, 4);
        do_run(1, 0);

        // bad configurations, then a full-length run out of ERR
        bad_cfg(0);
        bad_cfg(SEQ_LEN + 1);
        bad_cfg(15);
        fill(1, 3);
        do_run(SEQ_LEN, 0);

        // start while busy is ignored
        fill(1, 5);
        do_run(3, 1);

        // randomized runs
        for (int r = 0; r < 3; r++) begin
            fill(1, 6);
            do_run($urandom_range(SEQ_LEN, 1), r[0]);
        end

        // reset in ATTN of token 1
        fill(2, 2);
        begin_run(3);
        guard = 0;
        while (!(qkv_seen == 2 && state_dbg == 3'd5) && guard < 400) begin
            tick();
            guard++;
        end
        chk("mr_reached_attn", state_dbg, 5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mr_state", state_dbg, 0);
        chk("mr_outs", {qkv_start, kv_write_en, qk_start, softmax_start,
                        attn_start, busy, done, error}, 0);
        chk("mr_tok", token_idx, 0);
        chk("mr_addr", kv_addr, 0);
        chk("mr_cnt", cycle_count, 0);
        repeat (5) tick();
        chk("mr_no_done", done_cnt, 0);
        chk("mr_idle", state_dbg, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
